// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache miss paths, the shared memory port and the arbiter.
// The master modport is the arbiter's view; the slave modport is the caches/memory view.
interface cache_mem_arbiter_if #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned LINE_SIZE = WORD_SIZE * LINE_WORDS;

    // I-cache line-fill path
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_done;
    logic [LINE_SIZE-1:0] i_line;

    // D-cache fill / write-through path
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_done;
    logic [LINE_SIZE-1:0] d_line;

    // Shared memory port
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [LINE_SIZE-1:0] mem_rdata;
    logic                 mem_ready;

    // Service counters
    logic [CNT_W-1:0]     i_count;
    logic [CNT_W-1:0]     d_count;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_done, i_line, d_done, d_line, mem_read, mem_write, mem_addr, mem_wdata,
               i_count, d_count
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_done, i_line, d_done, d_line, mem_read, mem_write, mem_addr, mem_wdata,
               i_count, d_count
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache fills and D-cache fills/writes.
// One transaction at a time: IDLE grants, BUSY holds the memory op until mem_ready, DONE pulses
// the granted port's done for one cycle. All outputs are registered.
module cache_mem_arbiter #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cache_mem_arbiter_if.master  bus
);
    localparam int unsigned LINE_SIZE = WORD_SIZE * LINE_WORDS;
    // Word-offset bits within a line; cleared to form the line base address for fills.
    localparam logic [WORD_SIZE-1:0] LINE_MASK = WORD_SIZE'(LINE_WORDS - 1);
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 port_q, port_d;
    logic                 we_q, we_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 i_done_q, i_done_d;
    logic                 d_done_q, d_done_d;
    logic [LINE_SIZE-1:0] i_line_q, i_line_d;
    logic [LINE_SIZE-1:0] d_line_q, d_line_d;
    logic [CNT_W-1:0]     i_count_q, i_count_d;
    logic [CNT_W-1:0]     d_count_q, d_count_d;
    logic [WORD_SIZE-1:0] req_addr;

    // Next-state and registered-output logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        i_line_d     = i_line_q;
        d_line_d     = d_line_q;
        i_count_d    = i_count_q;
        d_count_d    = d_count_q;
        req_addr     = '0;

        case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    // Contention goes to the port that was not served last.
                    port_d       = (bus.i_req && bus.d_req) ? ~last_grant_q : bus.d_req;
                    we_d         = (port_d == PORT_D) && bus.d_we;
                    req_addr     = (port_d == PORT_D) ? bus.d_addr : bus.i_addr;
                    mem_addr_d   = we_d ? req_addr : (req_addr & ~LINE_MASK);
                    mem_wdata_d  = bus.d_wdata;
                    mem_read_d   = ~we_d;
                    mem_write_d  = we_d;
                    last_grant_d = port_d;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                if (bus.mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (port_q == PORT_D) begin
                        d_done_d  = 1'b1;
                        d_count_d = d_count_q + CNT_W'(1);
                        if (!we_q) begin
                            d_line_d = bus.mem_rdata;
                        end
                    end else begin
                        i_done_d  = 1'b1;
                        i_count_d = i_count_q + CNT_W'(1);
                        i_line_d  = bus.mem_rdata;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= PORT_I;
            port_q       <= PORT_I;
            we_q         <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_line_q     <= '0;
            d_line_q     <= '0;
            i_count_q    <= '0;
            d_count_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            i_line_q     <= i_line_d;
            d_line_q     <= d_line_d;
            i_count_q    <= i_count_d;
            d_count_q    <= d_count_d;
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_line    = i_line_q;
    assign bus.d_line    = d_line_q;
    assign bus.i_count   = i_count_q;
    assign bus.d_count   = d_count_q;
endmodule
